// File: rtl/calculo_acumulador.sv
// Block accumulator: sums 2^n_log2 signed samples and holds the sum plus a done level for the PIO.
// Optional macro CALC_ACUM_AVG_DIVIDE_EN turns the sum into a block average (arithmetic shift by n_log2).
module calculo_acumulador #(
    parameter  int DATA_W   = 14,
    parameter  int MAX_LOG2 = 16,
    localparam int ACC_W    = DATA_W + MAX_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        n_log2,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic [ACC_W-1:0]  result,
    output logic              calculo_finalizado,
    output logic              busy,
    output logic [MAX_LOG2:0] sample_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] MAX_LOG2_W = 5'(MAX_LOG2);

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   sum_next;
    logic [4:0]                n_lat;
    logic [4:0]                n_clamped;
    logic [MAX_LOG2:0]         count_next;
    logic [MAX_LOG2:0]         target;

    always_comb begin
        sample_ext = {{MAX_LOG2{data_in[DATA_W-1]}}, data_in};
        sum_next   = acc + sample_ext;
        count_next = sample_count + (MAX_LOG2 + 1)'(1);
        target     = (MAX_LOG2 + 1)'(1) << n_lat;
        n_clamped  = (n_log2 > MAX_LOG2_W) ? MAX_LOG2_W : n_log2;
    end

    // NOTE: every register in this block uses non-blocking assignment so all
    // updates see the pre-edge values, matching the hardware they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            acc                <= '0;
            n_lat              <= '0;
            sample_count       <= '0;
            result             <= '0;
            calculo_finalizado <= 1'b0;
            busy               <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state              <= ACCUM;
                        n_lat              <= n_clamped;
                        acc                <= '0;
                        sample_count       <= '0;
                        calculo_finalizado <= 1'b0;
                        busy               <= 1'b1;
                    end
                end
                ACCUM: begin
                    // A start here restarts the block and drops the sample on that cycle.
                    if (start) begin
                        n_lat        <= n_clamped;
                        acc          <= '0;
                        sample_count <= '0;
                    end else if (data_valid) begin
                        sample_count <= count_next;
                        if (count_next == target) begin
`ifdef CALC_ACUM_AVG_DIVIDE_EN
                            result <= sum_next >>> n_lat;
`else
                            result <= sum_next;
`endif
                            acc                <= '0;
                            calculo_finalizado <= 1'b1;
                            busy               <= 1'b0;
                            state              <= DONE;
                        end else begin
                            acc <= sum_next;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
